seg7_stream_decoder: RTL

Receive-side counterpart of the seven-segment driver. It watches a 7-bit segment bus, such as the design's own `uo_out[6:0]` looped back or an external display bus. It filters out glitches, decodes each stable pattern back to a decimal digit, and checks that successive digits follow the counting order (0..WRAP, then back to 0). Benches use it as a self-check monitor, and it is also built in silicon as a loopback checker.

---
 rtl/seg7_stream_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_stream_decoder.sv
// seg7_stream_decoder
// Watches a 7-segment bus and filters out glitches. Each stable pattern is
// decoded back to a decimal digit, and the monitor checks that successive
// digits follow the counting order 0..WRAP, then 0 again.
// Every output is a flop or a decode of flops. There is no combinational
// path from segments_i to any output.

module seg7_stream_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int WRAP          = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments_i,
    output logic [3:0] digit_o,
    output logic       digit_valid_o,
    output logic       blank_o,
    output logic       invalid_pattern_o,
    output logic       seq_error_o,
    output logic       locked_o,
    output logic [7:0] digit_count_o
);

    // stab value reached on the edge that completes the filter, and the value just before it
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] STAB_PRE  = 8'(STABLE_CYCLES - 2);
    localparam logic [3:0] WRAP_DIG  = 4'(WRAP);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Pattern to {is_digit, digit}; anything that is not a digit returns 0
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = 5'b1_0000;
            7'h06:   res = 5'b1_0001;
            7'h5B:   res = 5'b1_0010;
            7'h4F:   res = 5'b1_0011;
            7'h66:   res = 5'b1_0100;
            7'h6D:   res = 5'b1_0101;
            7'h7D:   res = 5'b1_0110;
            7'h07:   res = 5'b1_0111;
            7'h7F:   res = 5'b1_1000;
            7'h6F:   res = 5'b1_1001;
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    logic [6:0] cand_q, cand_d;
    logic [7:0] stab_q, stab_d;
    logic [6:0] acc_q,  acc_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] digit_q, digit_d;
    logic [7:0] count_q, count_d;
    logic       dv_q, dv_d;
    logic       blank_q, blank_d;
    logic       inv_q, inv_d;
    logic       serr_q, serr_d;
    state_t     state_q, state_d;

    logic       same_s;
    logic       accept_s;
    logic [4:0] dec_s;
    logic       is_digit_s;
    logic       is_blank_s;
    logic [3:0] expected_s;

    // Acceptance fires on the edge where stab would reach its final value,
    // so a value first sampled at edge k is accepted at edge k+STABLE_CYCLES-1
    assign same_s     = (segments_i == cand_q);
    assign accept_s   = same_s && (stab_q >= STAB_PRE) && (cand_q != acc_q);
    assign dec_s      = decode_seg(cand_q);
    assign is_digit_s = dec_s[4];
    assign is_blank_s = (cand_q == 7'h00);
    assign expected_s = (prev_q == WRAP_DIG) ? 4'd0 : (prev_q + 4'd1);

    // Stability filter: track candidate, count identical samples, latch accepted pattern
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        acc_d  = acc_q;
        if (!same_s) begin
            cand_d = segments_i;
            stab_d = 8'd0;
        end else if (stab_q < STAB_LAST) begin
            stab_d = stab_q + 8'd1;
        end else begin
            stab_d = stab_q;
        end
        if (accept_s) begin
            acc_d = cand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Event classification: digit / blank / invalid, with sequence check and counter
    always_comb begin
        digit_d = digit_q;
        prev_d  = prev_q;
        count_d = count_q;
        dv_d    = 1'b0;
        blank_d = 1'b0;
        inv_d   = 1'b0;
        serr_d  = 1'b0;
        if (accept_s && is_digit_s) begin
            digit_d = dec_s[3:0];
            prev_d  = dec_s[3:0];
            dv_d    = 1'b1;
            serr_d  = (state_q == ST_LOCKED) && (dec_s[3:0] != expected_s);
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end else begin
                count_d = count_q;
            end
        end else if (accept_s && is_blank_s) begin
            blank_d = 1'b1;
        end else if (accept_s) begin
            inv_d = 1'b1;
        end else begin
            dv_d = 1'b0;
        end
    end

    // Lock FSM next state: lock on any digit, unlock on an invalid pattern
    always_comb begin
        state_d = state_q;
        if (accept_s && is_digit_s) begin
            state_d = ST_LOCKED;
        end else if (accept_s && !is_blank_s) begin
            state_d = ST_UNLOCKED;
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q  <= 7'h00;
            stab_q  <= 8'd0;
            acc_q   <= 7'h00;
            prev_q  <= 4'd0;
            digit_q <= 4'd0;
            count_q <= 8'd0;
            dv_q    <= 1'b0;
            blank_q <= 1'b0;
            inv_q   <= 1'b0;
            serr_q  <= 1'b0;
            state_q <= ST_UNLOCKED;
        end else begin
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            acc_q   <= acc_d;
            prev_q  <= prev_d;
            digit_q <= digit_d;
            count_q <= count_d;
            dv_q    <= dv_d;
            blank_q <= blank_d;
            inv_q   <= inv_d;
            serr_q  <= serr_d;
            state_q <= state_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        locked_o          = (state_q == ST_LOCKED);
        digit_o           = digit_q;
        digit_valid_o     = dv_q;
        blank_o           = blank_q;
        invalid_pattern_o = inv_q;
        seq_error_o       = serr_q;
        digit_count_o     = count_q;
    end

endmodule
